// File: rtl/kpscan.sv
// rtl/kpscan.sv - 4x4 keypad column scanner with row synchroniser and press/release debounce
//
// Purpose:
//    Rotates an active-low one-hot column select across the keypad, synchronises
//    the raw rows for the external decoder, and turns the decoder's kphit/num into
//    one debounced key event per physical press.
//
// Ports:
//    clk        system clock, rising edge
//    reset_n    asynchronous active-low reset
//    kpr        raw keypad rows, active-low, asynchronous to clk
//    kphit      decoder key-present flag (from kpr_sync and kpc)
//    num        decoder key code
//    kpc        column select, one-hot active-low, registered
//    kpr_sync   kpr after a 2-flop synchroniser, feeds the decoder
//    key_valid  one-cycle pulse when a debounced press is accepted
//    key_num    code of the last accepted key
//    key_held   high from accept until the release is debounced

module kpscan #(
   parameter int SCAN_DIV   = 1000,
   parameter int DEB_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] kpr,
   input  logic       kphit,
   input  logic [3:0] num,
   output logic [3:0] kpc,
   output logic [3:0] kpr_sync,
   output logic       key_valid,
   output logic [3:0] key_num,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(DEB_CYCLES);

   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_LAST = BW'(DEB_CYCLES - 1);
   // The zero cycle seen in HELD counts toward the release, so RELEASE
   // itself only needs DEB_CYCLES-1 zeros: leave when the count would reach it.
   localparam logic [BW-1:0] REL_LAST = BW'(DEB_CYCLES - 2);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t        state, state_d;
   logic [3:0]    sync1;
   logic [DW-1:0] div_cnt, div_d;
   logic [BW-1:0] deb_cnt, deb_d;
   logic [3:0]    cand, cand_d;
   logic [3:0]    kpc_d, kpc_rot;
   logic          valid_d, held_d;
   logic [3:0]    num_d;
   logic          key_match;

   // Row synchroniser; reset to idle (no row pulled low).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= 4'b1111;
         kpr_sync <= 4'b1111;
      end else begin
         sync1    <= kpr;
         kpr_sync <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= SCAN;
         kpc       <= 4'b0111;
         div_cnt   <= '0;
         deb_cnt   <= '0;
         cand      <= 4'h0;
         key_valid <= 1'b0;
         key_num   <= 4'h0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_d;
         kpc       <= kpc_d;
         div_cnt   <= div_d;
         deb_cnt   <= deb_d;
         cand      <= cand_d;
         key_valid <= valid_d;
         key_num   <= num_d;
         key_held  <= held_d;
      end
   end

   // Rotate the single low bit one place to the right: 0111 -> 1011 -> ...
   assign kpc_rot   = {kpc[0], kpc[3:1]};
   assign key_match = kphit && (num == cand);

   always_comb begin
      state_d = state;
      kpc_d   = kpc;
      div_d   = '0;
      deb_d   = deb_cnt;
      cand_d  = cand;
      valid_d = 1'b0;
      num_d   = key_num;
      held_d  = key_held;

      case (state)
         SCAN: begin
            deb_d = '0;
            // Only look at kphit at the end of the dwell so the synchroniser
            // has settled on the current column.
            if (div_cnt == DIV_LAST) begin
               if (kphit) begin
                  cand_d  = num;
                  state_d = DEBOUNCE;
               end else begin
                  kpc_d = kpc_rot;
               end
            end else begin
               div_d = div_cnt + 1'b1;
            end
         end

         DEBOUNCE: begin
            if (!key_match) begin
               state_d = SCAN;
               kpc_d   = kpc_rot;
               deb_d   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               valid_d = 1'b1;
               num_d   = cand;
               held_d  = 1'b1;
               deb_d   = '0;
               state_d = HELD;
            end else begin
               deb_d = deb_cnt + 1'b1;
            end
         end

         HELD: begin
            // A different code while held is ignored: no roll-over.
            if (!kphit) begin
               deb_d   = '0;
               state_d = RELEASE;
            end
         end

         RELEASE: begin
            if (kphit) begin
               deb_d   = '0;
               state_d = HELD;
            end else if (deb_cnt == REL_LAST) begin
               held_d  = 1'b0;
               kpc_d   = kpc_rot;
               deb_d   = '0;
               state_d = SCAN;
            end else begin
               deb_d = deb_cnt + 1'b1;
            end
         end

         default: begin
            state_d = SCAN;
            deb_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_kpscan.sv
// tb/tb_kpscan.sv - directed self-checking bench for kpscan with keypad and decoder models

module tb_kpscan;

   logic       clk;
   logic       reset_n;
   logic [3:0] kpr;
   logic       kphit;
   logic [3:0] num;
   logic [3:0] kpc;
   logic [3:0] kpr_sync;
   logic       key_valid;
   logic [3:0] key_num;
   logic       key_held;

   int checks = 0;
   int errors = 0;
   int vp_cnt = 0;
   int glitch = 0;

   // keypad model: one pressed key at (prow, pcol)
   logic       press;
   int         prow, pcol;
   // decoder override for codes a real keypad cannot produce with a frozen column
   logic       ovr, ovr_hit;
   logic [3:0] ovr_num;

   logic [3:0] cols [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
   logic [3:0] km [16]  = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

   kpscan #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
      .clk(clk), .reset_n(reset_n), .kpr(kpr), .kphit(kphit), .num(num),
      .kpc(kpc), .kpr_sync(kpr_sync), .key_valid(key_valid),
      .key_num(key_num), .key_held(key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int idx(input logic [3:0] v);
      case (v)
         4'b0111: return 0;
         4'b1011: return 1;
         4'b1101: return 2;
         4'b1110: return 3;
         default: return -1;
      endcase
   endfunction

   assign kpr = (press && kpc == cols[pcol]) ? cols[prow] : 4'b1111;

   logic       mhit;
   logic [3:0] mnum;
   int         dr, dc;
   always_comb begin
      mhit = 1'b0;
      mnum = 4'h0;
      dr   = idx(kpr_sync);
      dc   = idx(kpc);
      if (dr >= 0 && dc >= 0) begin
         mhit = 1'b1;
         mnum = km[dr*4 + dc];
      end
   end
   assign kphit = ovr ? ovr_hit : mhit;
   assign num   = ovr ? ovr_num : mnum;

   always @(negedge clk) begin
      if (key_valid === 1'b1) vp_cnt++;
      if (!reset_n && key_valid !== 1'b0) glitch++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int lim, output int got);
      got = 0;
      for (int i = 0; i < lim; i++) begin
         step();
         if (key_valid === 1'b1) begin
            got = 1;
            break;
         end
      end
   endtask

   task automatic wait_release(input int lim, output int got);
      got = 0;
      for (int i = 0; i < lim; i++) begin
         step();
         if (key_held === 1'b0) begin
            got = 1;
            break;
         end
      end
   endtask

   initial begin
      int         got;
      int         base;
      logic       held_ok;
      logic [3:0] frozen;
      logic [3:0] prev;

      reset_n = 1'b0; press = 1'b0; prow = 0; pcol = 0;
      ovr = 1'b0; ovr_hit = 1'b0; ovr_num = 4'h0;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_kpc", kpc, 4'b0111);
      chk("rst_kpr_sync", kpr_sync, 4'b1111);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_num", key_num, 4'h0);
      chk("rst_held", key_held, 1'b0);
      reset_n = 1'b1;

      // idle scan: column changes every 4 cycles
      for (int k = 1; k <= 40; k++) begin
         step();
         chk("scan_kpc", kpc, cols[(k / 4) % 4]);
      end
      chk("idle_pulses", vp_cnt, 0);
      chk("idle_held", key_held, 1'b0);

      // key 5 held 30 cycles: column 1011 arrives at edge 12, sampled edge 16, pulse after edge 24
      prow = 1; pcol = 1; press = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         chk("k5_valid", key_valid, (i == 23));
         if (i == 23) chk("k5_num", key_num, 4'h5);
         if (i == 29) chk("k5_frozen", kpc, 4'b1011);
      end
      press = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         step();
         chk("k5_held", key_held, (j < 10));
      end
      chk("k5_resume_kpc", kpc, 4'b1101);
      chk("k5_pulses", vp_cnt, 1);

      // key 2 bouncing 3 on / 1 off, then stable
      prow = 0; pcol = 1;
      base = vp_cnt;
      for (int i = 0; i < 40; i++) begin
         press = (i % 4 != 3);
         step();
      end
      chk("k2_bounce_pulses", vp_cnt - base, 0);
      press = 1'b1;
      wait_valid(60, got);
      chk("k2_seen", got, 1);
      chk("k2_num", key_num, 4'h2);
      chk("k2_held", key_held, 1'b1);
      press = 1'b0;
      wait_release(40, got);
      chk("k2_release", got, 1);
      chk("k2_pulses", vp_cnt - base, 1);

      // key 9 held 200 cycles with a 3-cycle dropout
      prow = 2; pcol = 2; press = 1'b1;
      base = vp_cnt;
      wait_valid(60, got);
      chk("k9_seen", got, 1);
      chk("k9_num", key_num, 4'h9);
      held_ok = 1'b1;
      for (int i = 0; i < 170; i++) begin
         press = !(i >= 80 && i <= 82);
         step();
         if (key_held !== 1'b1) held_ok = 1'b0;
      end
      chk("k9_held_through_dropout", held_ok, 1'b1);
      chk("k9_pulses", vp_cnt - base, 1);
      press = 1'b0;
      wait_release(40, got);
      chk("k9_release", got, 1);

      // code changes B -> 6 at debounce count 5
      ovr = 1'b1; ovr_hit = 1'b0; ovr_num = 4'h0;
      prev = kpc;
      got = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (kpc !== prev) begin
            got = 1;
            break;
         end
      end
      chk("chg_sync", got, 1);
      frozen = kpc;
      ovr_hit = 1'b1; ovr_num = 4'hB;
      for (int j = 1; j <= 24; j++) begin
         step();
         if (j == 9) begin
            chk("chg_frozen", kpc, frozen);
            ovr_num = 4'h6;
         end
         if (j == 10) chk("chg_advance", kpc, {frozen[0], frozen[3:1]});
         chk("chg_valid", key_valid, (j == 22));
         if (j == 22) chk("chg_num", key_num, 4'h6);
      end
      chk("chg_held", key_held, 1'b1);

      // asynchronous reset mid-HELD
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("rh_kpc", kpc, 4'b0111);
      chk("rh_kpr_sync", kpr_sync, 4'b1111);
      chk("rh_valid", key_valid, 1'b0);
      chk("rh_num", key_num, 4'h0);
      chk("rh_held", key_held, 1'b0);

      // asynchronous reset mid-DEBOUNCE (entered at edge 4, count 2 after edge 6)
      ovr_hit = 1'b1; ovr_num = 4'hA;
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("rd_frozen", kpc, 4'b0111);
      chk("rd_valid_pre", key_valid, 1'b0);
      #3 reset_n = 1'b0;
      #1;
      chk("rd_kpc", kpc, 4'b0111);
      chk("rd_valid", key_valid, 1'b0);
      chk("rd_held", key_held, 1'b0);
      chk("rd_num", key_num, 4'h0);
      repeat (3) step();
      chk("rst_glitch", glitch, 0);

      ovr = 1'b0;
      reset_n = 1'b1;
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
